// File: rtl/rx_cmd_decoder_pkg.sv
// Shared definitions for the receive command decoder: opcode bytes,
// FSM state encoding and fixed register addresses of the ALU operands.
package cmd_pkg;

  // Command opcodes (first byte of every frame)
  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register-file slots the ALU reads its operands from
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_ALU_A,
    ST_ALU_B,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX_LO,
    ST_TX_HI
  } state_t;

  // True for the two states that wait on a register-file / ALU result
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_RD_WAIT) || (s == ST_ALU_WAIT);
  endfunction

endpackage

// File: rtl/rx_cmd_decoder_if.sv
// Bundle of every signal between the command decoder and its neighbours
// (receive synchronizer, register file, ALU, transmit path).
// master = the decoder, slave = the surrounding system.
interface rx_cmd_decoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int ALU_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [ALU_WIDTH-1:0]  alu_out;
  logic                  alu_valid;
  logic                  tx_busy;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  alu_en;
  logic [FUN_WIDTH-1:0]  alu_fun;
  logic                  clk_gate_en;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  err;

  modport master (
    input  rx_data, rx_valid, rd_data, rd_valid, alu_out, alu_valid, tx_busy,
    output wr_en, rd_en, addr, wr_data, alu_en, alu_fun, clk_gate_en,
           tx_data, tx_valid, err
  );

  modport slave (
    output rx_data, rx_valid, rd_data, rd_valid, alu_out, alu_valid, tx_busy,
    input  wr_en, rd_en, addr, wr_data, alu_en, alu_fun, clk_gate_en,
           tx_data, tx_valid, err
  );

endinterface

// File: rtl/rx_cmd_decoder_timeout.sv
// Wait-state watchdog: reloads while idle, counts down while the decoder
// waits for a result, and flags expiry on the TIMEOUT-th waiting cycle.
module rx_cmd_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // Reload to TIMEOUT-1 so the first waiting cycle already sees one step used
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= CW'(TIMEOUT - 1);
    end else if (load) begin
      cnt_q <= CW'(TIMEOUT - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/rx_cmd_decoder.sv
// Command frame decoder: parses synchronized receive bytes into register
// writes/reads and ALU operations, then returns results as tx bytes.
// Every output is a flop; strobes appear the cycle after the causing byte.
module rx_cmd_decoder
  import cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int ALU_WIDTH  = 16,
  parameter int TIMEOUT    = 15
) (
  input logic             CLK,
  input logic             RST,
  rx_cmd_decoder_if.master bus
);

  state_t                state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  alu_en_q, alu_en_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
  logic                  clk_gate_q, clk_gate_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  err_q, err_d;
  logic [ALU_WIDTH-1:0]  resp_q, resp_d;     // result waiting to be sent
  logic                  is_alu_q, is_alu_d; // response has a high byte
  logic                  tx_sent_q, tx_sent_d; // current tx byte already strobed
  logic                  wait_expired;

  rx_cmd_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .load    (!is_wait_state(state_q)),
    .expired (wait_expired)
  );

  // State and output registers; reset abandons any partial frame
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      alu_en_q   <= 1'b0;
      alu_fun_q  <= '0;
      clk_gate_q <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      resp_q     <= '0;
      is_alu_q   <= 1'b0;
      tx_sent_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      alu_en_q   <= alu_en_d;
      alu_fun_q  <= alu_fun_d;
      clk_gate_q <= clk_gate_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      resp_q     <= resp_d;
      is_alu_q   <= is_alu_d;
      tx_sent_q  <= tx_sent_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    // NOTE: defaults first (strobes low, data held) so no path infers a latch.
    state_d    = state_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    tx_valid_d = 1'b0;
    err_d      = 1'b0;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    alu_fun_d  = alu_fun_q;
    tx_data_d  = tx_data_q;
    resp_d     = resp_q;
    is_alu_d   = is_alu_q;
    tx_sent_d  = tx_sent_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            DATA_WIDTH'(CMD_WR):      state_d = ST_WR_ADDR;
            DATA_WIDTH'(CMD_RD):      state_d = ST_RD_ADDR;
            DATA_WIDTH'(CMD_ALU_OP):  state_d = ST_ALU_A;
            DATA_WIDTH'(CMD_ALU_NOP): state_d = ST_ALU_FUN;
            default:                  err_d   = 1'b1;
          endcase
        end
      end

      ST_WR_ADDR: begin
        if (bus.rx_valid) begin
          addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
          state_d = ST_WR_DATA;
        end
      end

      ST_WR_DATA: begin
        if (bus.rx_valid) begin
          wr_en_d   = 1'b1;
          wr_data_d = bus.rx_data;
          state_d   = ST_IDLE;
        end
      end

      ST_RD_ADDR: begin
        if (bus.rx_valid) begin
          rd_en_d = 1'b1;
          addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        err_d = bus.rx_valid;  // overrun: byte dropped, state kept
        if (bus.rd_valid) begin
          resp_d   = {{(ALU_WIDTH-DATA_WIDTH){1'b0}}, bus.rd_data};
          is_alu_d = 1'b0;
          state_d  = ST_TX_LO;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_ALU_A: begin
        if (bus.rx_valid) begin
          wr_en_d   = 1'b1;
          addr_d    = ADDR_WIDTH'(OPA_ADDR);
          wr_data_d = bus.rx_data;
          state_d   = ST_ALU_B;
        end
      end

      ST_ALU_B: begin
        if (bus.rx_valid) begin
          wr_en_d   = 1'b1;
          addr_d    = ADDR_WIDTH'(OPB_ADDR);
          wr_data_d = bus.rx_data;
          state_d   = ST_ALU_FUN;
        end
      end

      ST_ALU_FUN: begin
        if (bus.rx_valid) begin
          alu_en_d  = 1'b1;
          alu_fun_d = bus.rx_data[FUN_WIDTH-1:0];
          state_d   = ST_ALU_WAIT;
        end
      end

      ST_ALU_WAIT: begin
        err_d = bus.rx_valid;
        if (bus.alu_valid) begin
          resp_d   = bus.alu_out;
          is_alu_d = 1'b1;
          state_d  = ST_TX_LO;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_TX_LO: begin
        err_d = bus.rx_valid;
        if (tx_sent_q) begin
          // busy is ignored here: the byte already went out last cycle
          tx_sent_d = 1'b0;
          state_d   = is_alu_q ? ST_TX_HI : ST_IDLE;
        end else if (!bus.tx_busy) begin
          tx_valid_d = 1'b1;
          tx_data_d  = resp_q[DATA_WIDTH-1:0];
          tx_sent_d  = 1'b1;
        end
      end

      ST_TX_HI: begin
        err_d = bus.rx_valid;
        if (tx_sent_q) begin
          tx_sent_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (!bus.tx_busy) begin
          tx_valid_d = 1'b1;
          tx_data_d  = resp_q[ALU_WIDTH-1 -: DATA_WIDTH];
          tx_sent_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ALU clock runs from entry to ALU_FUN until the result is taken or abandoned
  always_comb begin
    clk_gate_d = (state_d == ST_ALU_FUN) || (state_d == ST_ALU_WAIT);
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.addr        = addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_fun     = alu_fun_q;
  assign bus.clk_gate_en = clk_gate_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Self-checking bench for rx_cmd_decoder: frame-level reference model
// compared every cycle, plus hand-computed checks at key points.
module tb_rx_cmd_decoder;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  rx_cmd_decoder_if bus ();

  rx_cmd_decoder dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int tx_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [7:0] frame[$];     // bytes of the frame being collected
  logic [7:0] txq[$];       // response bytes still to transmit
  bit         waiting = 0;
  bit         wait_alu = 0;
  int         wait_left = 0;
  bit         just_sent = 0;
  logic       m_wr_en = 0, m_rd_en = 0, m_alu_en = 0, m_tx_valid = 0;
  logic       m_err = 0, m_clk_gate = 0;
  logic [3:0] m_addr = 0, m_alu_fun = 0;
  logic [7:0] m_wr_data = 0, m_tx_data = 0;

  task automatic start_wait(input bit alu);
    waiting   = 1;
    wait_alu  = alu;
    wait_left = 15;
  endtask

  task automatic model_step();
    logic [7:0] b;
    m_wr_en = 0; m_rd_en = 0; m_alu_en = 0; m_tx_valid = 0; m_err = 0;
    b = bus.rx_data;
    if (txq.size() != 0) begin
      if (bus.rx_valid) m_err = 1;
      if (just_sent) begin
        void'(txq.pop_front());
        just_sent = 0;
      end else if (!bus.tx_busy) begin
        m_tx_valid = 1;
        m_tx_data  = txq[0];
        just_sent  = 1;
      end
    end else if (waiting) begin
      if (bus.rx_valid) m_err = 1;
      if (wait_alu ? bus.alu_valid : bus.rd_valid) begin
        if (wait_alu) begin
          txq.push_back(bus.alu_out[7:0]);
          txq.push_back(bus.alu_out[15:8]);
        end else begin
          txq.push_back(bus.rd_data);
        end
        waiting = 0;
      end else if (wait_left == 1) begin
        m_err   = 1;
        waiting = 0;
      end else begin
        wait_left--;
      end
    end else if (bus.rx_valid) begin
      frame.push_back(b);
      case (frame[0])
        8'hAA: begin
          if (frame.size() == 2) m_addr = b[3:0];
          else if (frame.size() == 3) begin
            m_wr_en = 1; m_wr_data = b; frame.delete();
          end
        end
        8'hBB: begin
          if (frame.size() == 2) begin
            m_rd_en = 1; m_addr = b[3:0]; start_wait(0); frame.delete();
          end
        end
        8'hCC: begin
          if (frame.size() == 2) begin
            m_wr_en = 1; m_addr = 4'd0; m_wr_data = b;
          end else if (frame.size() == 3) begin
            m_wr_en = 1; m_addr = 4'd1; m_wr_data = b;
          end else if (frame.size() == 4) begin
            m_alu_en = 1; m_alu_fun = b[3:0]; start_wait(1); frame.delete();
          end
        end
        8'hDD: begin
          if (frame.size() == 2) begin
            m_alu_en = 1; m_alu_fun = b[3:0]; start_wait(1); frame.delete();
          end
        end
        default: begin
          m_err = 1;
          frame.delete();
        end
      endcase
    end
    m_clk_gate = (waiting && wait_alu) ||
                 (frame.size() == 3 && frame[0] == 8'hCC) ||
                 (frame.size() == 1 && frame[0] == 8'hDD);
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame.delete(); txq.delete();
      waiting = 0; wait_alu = 0; wait_left = 0; just_sent = 0;
      m_wr_en = 0; m_rd_en = 0; m_alu_en = 0; m_tx_valid = 0; m_err = 0;
      m_clk_gate = 0; m_addr = 0; m_alu_fun = 0; m_wr_data = 0; m_tx_data = 0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison, sampled mid-cycle
  always @(negedge CLK) begin
    check("wr_en", bus.wr_en, m_wr_en);
    check("rd_en", bus.rd_en, m_rd_en);
    check("alu_en", bus.alu_en, m_alu_en);
    check("tx_valid", bus.tx_valid, m_tx_valid);
    check("err", bus.err, m_err);
    check("clk_gate_en", bus.clk_gate_en, m_clk_gate);
    if (m_wr_en || m_rd_en) check("addr", bus.addr, m_addr);
    if (m_wr_en) check("wr_data", bus.wr_data, m_wr_data);
    if (m_alu_en) check("alu_fun", bus.alu_fun, m_alu_fun);
    if (m_tx_valid) check("tx_data", bus.tx_data, m_tx_data);
    if (bus.tx_valid) tx_count++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  // Wait (bounded) for the next tx strobe and check its byte
  task automatic wait_tx(input logic [7:0] exp, input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus.tx_valid) seen = 1;
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    if (seen) check(name, bus.tx_data, exp);
  endtask

  int tx_base;

  initial begin
    bus.rx_data = 0; bus.rx_valid = 0; bus.rd_data = 0; bus.rd_valid = 0;
    bus.alu_out = 0; bus.alu_valid = 0; bus.tx_busy = 0;
    #1;
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_err", bus.err, 0);
    ticks(3);
    RST = 1'b0;
    tick();

    // Write frame
    tx_base = tx_count;
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    check("wr_strobe", bus.wr_en, 1);
    check("wr_addr", bus.addr, 4'h5);
    check("wr_data_lit", bus.wr_data, 8'h3C);
    tick();
    check("wr_one_cycle", bus.wr_en, 0);
    check("wr_no_tx", tx_count - tx_base, 0);

    // Read frame
    tx_base = tx_count;
    send_byte(8'hBB); send_byte(8'h07);
    check("rd_strobe", bus.rd_en, 1);
    check("rd_addr", bus.addr, 4'h7);
    ticks(2);
    bus.rd_valid = 1; bus.rd_data = 8'h9E;
    tick();
    bus.rd_valid = 0;
    wait_tx(8'h9E, "rd_tx");
    ticks(3);
    check("rd_tx_once", tx_count - tx_base, 1);

    // ALU_OP frame with a busy transmitter and an overrun byte
    tx_base = tx_count;
    send_byte(8'hCC); send_byte(8'h12);
    check("opa_addr", bus.addr, 4'h0);
    check("opa_data", bus.wr_data, 8'h12);
    send_byte(8'h34);
    check("opb_addr", bus.addr, 4'h1);
    check("opb_data", bus.wr_data, 8'h34);
    check("gate_at_fun", bus.clk_gate_en, 1);
    send_byte(8'h02);
    check("alu_strobe", bus.alu_en, 1);
    check("alu_fun_lit", bus.alu_fun, 4'h2);
    bus.tx_busy = 1;
    ticks(2);
    check("gate_in_wait", bus.clk_gate_en, 1);
    bus.alu_valid = 1; bus.alu_out = 16'hABCD;
    tick();
    bus.alu_valid = 0;
    check("gate_dropped", bus.clk_gate_en, 0);
    send_byte(8'h99);
    check("tx_overrun_err", bus.err, 1);
    ticks(4);
    check("no_tx_while_busy", tx_count - tx_base, 0);
    bus.tx_busy = 0;
    wait_tx(8'hCD, "alu_lo");
    bus.tx_busy = 1;
    ticks(5);
    check("hi_held_by_busy", tx_count - tx_base, 1);
    bus.tx_busy = 0;
    wait_tx(8'hAB, "alu_hi");
    ticks(3);
    check("alu_tx_twice", tx_count - tx_base, 2);

    // Bad opcode, then read timeout
    tx_base = tx_count;
    send_byte(8'h55);
    check("bad_op_err", bus.err, 1);
    send_byte(8'hBB); send_byte(8'h01);
    ticks(14);
    check("no_early_timeout", bus.err, 0);
    tick();
    check("timeout_err", bus.err, 1);
    tick();
    check("timeout_no_tx", tx_count - tx_base, 0);

    // Overrun during RD_WAIT, read still completes
    send_byte(8'hBB); send_byte(8'h03);
    send_byte(8'h77);
    check("wait_overrun_err", bus.err, 1);
    bus.rd_valid = 1; bus.rd_data = 8'h5A;
    tick();
    bus.rd_valid = 0;
    wait_tx(8'h5A, "overrun_rd_tx");
    ticks(2);

    // Valid on the expiry cycle wins over the timeout
    send_byte(8'hBB); send_byte(8'h02);
    ticks(14);
    bus.rd_valid = 1; bus.rd_data = 8'h3E;
    tick();
    bus.rd_valid = 0;
    check("expiry_valid_no_err", bus.err, 0);
    wait_tx(8'h3E, "expiry_rd_tx");
    ticks(2);

    // ALU_NOP with immediate result, then an ALU wait timeout
    send_byte(8'hDD);
    check("nop_gate", bus.clk_gate_en, 1);
    send_byte(8'h05);
    check("nop_fun", bus.alu_fun, 4'h5);
    bus.alu_valid = 1; bus.alu_out = 16'h1234;
    tick();
    bus.alu_valid = 0;
    wait_tx(8'h34, "nop_lo");
    wait_tx(8'h12, "nop_hi");
    ticks(2);
    send_byte(8'hDD); send_byte(8'h04);
    ticks(15);
    check("alu_timeout_err", bus.err, 1);
    check("alu_timeout_gate", bus.clk_gate_en, 0);
    tick();

    // Stray result strobes in IDLE are ignored
    tx_base = tx_count;
    bus.rd_valid = 1; bus.alu_valid = 1;
    tick();
    bus.rd_valid = 0; bus.alu_valid = 0;
    ticks(3);
    check("stray_valid_no_tx", tx_count - tx_base, 0);

    // Reset mid-frame
    send_byte(8'hAA); send_byte(8'h05);
    check("pre_rst_addr", bus.addr, 4'h5);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_addr", bus.addr, 0);
    check("mid_rst_gate", bus.clk_gate_en, 0);
    check("mid_rst_wr_en", bus.wr_en, 0);
    tick();
    RST = 1'b0;
    tick();
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
    check("post_rst_wr", bus.wr_en, 1);
    check("post_rst_addr", bus.addr, 4'h2);
    check("post_rst_data", bus.wr_data, 8'h11);
    ticks(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
